// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer
//   In-order writeback FIFO sitting between the ALU and the register-file
//   write port. Each accepted ALU beat that really writes a register
//   (ex_we_i=1, ex_rd_i!=0) is stored as {rd, result} and presented in order
//   on the wb_* port.
//
//   Optional feature macro: ALU_WB_FWD_EN. When it is defined, a
//   combinational lookup port forwards in-flight results to operand fetch.
//
// Parameters
//   DEPTH  : number of entries (power of two, >= 2)
//   ADDR_W : register index width
//   DATA_W : result width
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   ex_valid_i   : ALU result present           ex_ready_o : buffer can accept
//   ex_we_i      : beat must be written back    ex_rd_i    : destination reg
//   ex_result_i  : ALU result
//   wb_valid_o   : head entry valid             wb_ready_i : write port takes head
//   wb_rd_o      : head destination reg         wb_result_o: head data
//   count_o      : occupied entries
//   fwd_rs_i / fwd_hit_o / fwd_data_o : forwarding lookup (ALU_WB_FWD_EN only)
//
// Handshake: a beat transfers on a port in a cycle where valid and ready are
// both 1 at the rising edge. ex_ready_o depends only on the registered count,
// so it never depends combinationally on wb_ready_i; wb_* hold their values
// while wb_valid_o=1 and wb_ready_i=0.
module alu_wb_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid_i,
  output logic                       ex_ready_o,
  input  logic                       ex_we_i,
  input  logic [ADDR_W-1:0]          ex_rd_i,
  input  logic [DATA_W-1:0]          ex_result_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [ADDR_W-1:0]          wb_rd_o,
  output logic [DATA_W-1:0]          wb_result_o,
`ifdef ALU_WB_FWD_EN
  input  logic [ADDR_W-1:0]          fwd_rs_i,
  output logic                       fwd_hit_o,
  output logic [DATA_W-1:0]          fwd_data_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              accept, push, pop;

  // Ready comes from the registered count alone: a full buffer refuses a
  // beat even when the head is popped in the same cycle.
  assign ex_ready_o = (count_q != FULL);
  assign wb_valid_o = (count_q != '0);
  assign count_o    = count_q;

  assign accept = ex_valid_i && ex_ready_o;
  // x0 writes and non-writing beats are consumed without touching state.
  assign push   = accept && ex_we_i && (ex_rd_i != '0);
  assign pop    = wb_valid_o && wb_ready_i;

  // Head slot drives the outputs directly; no bypass from the input.
  assign wb_rd_o     = rd_mem_q[rd_ptr_q];
  assign wb_result_o = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        rd_mem_q[wr_ptr_q]   <= ex_rd_i;
        data_mem_q[wr_ptr_q] <= ex_result_i;
      end
    end
  end

`ifdef ALU_WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  // Only registered storage is searched; a beat being pushed now is unseen.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (fwd_rs_i != '0) &&
          (rd_mem_q[fwd_idx] == fwd_rs_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_mem_q[fwd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Testbench for alu_wb_buffer. A queue of {rd, result} entries models the
// buffer contents; it is advanced from the inputs seen at each rising edge.
module tb_alu_wb_buffer;
`ifdef ALU_WB_FWD_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int EW     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_ready, ex_we;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_result;
  logic              wb_valid, wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic [CW-1:0]     count;
`ifdef ALU_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_rs;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_we_i(ex_we),
    .ex_rd_i(ex_rd), .ex_result_i(ex_result),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_rd_o(wb_rd), .wb_result_o(wb_result),
`ifdef ALU_WB_FWD_EN
    .fwd_rs_i(fwd_rs), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
`endif
    .count_o(count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_ex(input logic v, input logic we,
                          input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] res);
    ex_valid  = v;
    ex_we     = we;
    ex_rd     = rd;
    ex_result = res;
  endtask

  // Advance one clock; the model follows the rules of the buffer.
  task automatic tick();
    bit acc, push, pop;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      acc  = ex_valid && (exp_q.size() != DEPTH);
      push = acc && ex_we && (ex_rd != 0);
      pop  = (exp_q.size() != 0) && wb_ready;
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back({ex_rd, ex_result});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_ready = 1'b0;
    drive_ex(0, 0, 0, 0);
`ifdef ALU_WB_FWD_EN
    fwd_rs = 0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
    checks++; if (wb_rd !== 0 || wb_result !== 0) begin
      errors++; $display("FAIL reset_wb_data got rd=%0d data=%h want 0/0", wb_rd, wb_result); end
`ifdef ALU_WB_FWD_EN
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 0) begin
      errors++; $display("FAIL reset_fwd got hit=%b data=%h want 0/0", fwd_hit, fwd_data); end
`endif
    drive_ex(1, 1, 5'd9, 32'h1234); tick();
    drive_ex(1, 1, 5'd10, 32'h5678); tick();
    checks++; if (count !== 2) begin errors++; $display("FAIL held_count got %0d want 2", count); end
    rst = 1'b1;
    drive_ex(1, 1, 5'd11, 32'h9abc);
    tick();
    rst = 1'b0;
    drive_ex(0, 0, 0, 0);
    checks++; if (count !== 0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL midreset got count=%0d valid=%b want 0/0", count, wb_valid); end
    tick();
    checks++; if (count !== 0) begin errors++; $display("FAIL midreset_ignore got %0d want 0", count); end
  endtask

  task automatic test_single();
    wb_ready = 1'b0;
    drive_ex(1, 1, 5'd5, 32'hDEADBEEF);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got valid=%b want 0", wb_valid); end
    tick();
    drive_ex(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_result !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL single_hold cyc %0d got v=%b rd=%0d data=%h want 1/5/deadbeef", i, wb_valid, wb_rd, wb_result);
      end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (count !== 0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop got count=%0d v=%b want 0/0", count, wb_valid); end
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] d;
    wb_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      d = 32'h11 * i;
      drive_ex(1, 1, ADDR_W'(i), d);
      tick();
    end
    checks++; if (ex_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      errors++; $display("FAIL full got ready=%b count=%0d want 0/%0d", ex_ready, count, DEPTH); end
    checks++; if (wb_result !== 32'h11 || wb_rd !== 5'd1) begin
      errors++; $display("FAIL full_head got rd=%0d data=%h want 1/11", wb_rd, wb_result); end
    // Extra beat offered while popping: must not be taken.
    d = 32'h11 * (DEPTH + 1);
    drive_ex(1, 1, ADDR_W'(DEPTH + 1), d);
    wb_ready = 1'b1;
    tick();
    drive_ex(0, 0, 0, 0);
    wb_ready = 1'b0;
    checks++; if (ex_ready !== 1'b1 || count !== CW'(DEPTH - 1)) begin
      errors++; $display("FAIL full_pop got ready=%b count=%0d want 1/%0d", ex_ready, count, DEPTH - 1); end
    checks++; if (wb_result !== 32'h22) begin
      errors++; $display("FAIL full_next_head got %h want 22", wb_result); end
    wb_ready = 1'b1;
    for (int i = 2; i <= DEPTH; i++) begin
      d = 32'h11 * i;
      checks++; if (wb_result !== d || wb_valid !== 1'b1) begin
        errors++; $display("FAIL full_drain %0d got v=%b data=%h want 1/%h", i, wb_valid, wb_result, d); end
      tick();
    end
    wb_ready = 1'b0;
    checks++; if (count !== 0) begin errors++; $display("FAIL full_drained got %0d want 0", count); end
  endtask

  task automatic test_drop();
    wb_ready = 1'b0;
    drive_ex(1, 1, 5'd0, 32'hFFFFFFFF);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL drop_x0_ready got %b want 1", ex_ready); end
    tick();
    checks++; if (count !== 0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL drop_x0 got count=%0d v=%b want 0/0", count, wb_valid); end
    drive_ex(1, 0, 5'd7, 32'h77);
    tick();
    drive_ex(0, 0, 0, 0);
    checks++; if (count !== 0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL drop_we0 got count=%0d v=%b r=%b want 0/0/1", count, wb_valid, ex_ready); end
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    wb_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive_ex(1, 1, ADDR_W'(c + 1), DATA_W'(c));
      else       drive_ex(0, 0, 0, 0);
      tick();
      checks++; if (count > 1) begin errors++; $display("FAIL stream_count cyc %0d got %0d want <=1", c, count); end
      if (wb_valid) begin
        checks++;
        if (wb_result !== DATA_W'(nxt) || wb_rd !== ADDR_W'(nxt + 1)) begin
          errors++; $display("FAIL stream_order got rd=%0d data=%0d want %0d/%0d", wb_rd, wb_result, nxt + 1, nxt);
        end
        nxt++;
      end
    end
    checks++; if (nxt != 8) begin errors++; $display("FAIL stream_total got %0d want 8", nxt); end
    wb_ready = 1'b0;
  endtask

`ifdef ALU_WB_FWD_EN
  task automatic test_fwd();
    wb_ready = 1'b0;
    drive_ex(1, 1, 5'd3, 32'hA); tick();
    drive_ex(1, 1, 5'd3, 32'hB); tick();
    drive_ex(1, 1, 5'd4, 32'hC); tick();
    drive_ex(0, 0, 0, 0);
    fwd_rs = 5'd3; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin
      errors++; $display("FAIL fwd_rs3 got hit=%b data=%h want 1/b", fwd_hit, fwd_data); end
    fwd_rs = 5'd4; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hC) begin
      errors++; $display("FAIL fwd_rs4 got hit=%b data=%h want 1/c", fwd_hit, fwd_data); end
    fwd_rs = 5'd0; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 0) begin
      errors++; $display("FAIL fwd_rs0 got hit=%b data=%h want 0/0", fwd_hit, fwd_data); end
    // A beat being pushed right now is not yet visible.
    fwd_rs = 5'd6;
    drive_ex(1, 1, 5'd6, 32'h66); #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got hit=%b want 0", fwd_hit); end
    tick();
    drive_ex(0, 0, 0, 0);
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h66) begin
      errors++; $display("FAIL fwd_next_cycle got hit=%b data=%h want 1/66", fwd_hit, fwd_data); end
    wb_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    wb_ready = 1'b0;
    fwd_rs = 5'd3; #1;
    checks++; if (count !== 0 || fwd_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_empty got count=%0d hit=%b want 0/0", count, fwd_hit); end
  endtask
`endif

  task automatic test_random();
    logic [EW-1:0] head;
    for (int c = 0; c < 400; c++) begin
      drive_ex($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
               ADDR_W'($urandom_range(0, 7)), $urandom);
      wb_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_WB_FWD_EN
      fwd_rs = ADDR_W'($urandom_range(0, 7));
`endif
      #1;
      checks++;
      if (count !== CW'(exp_q.size()) || wb_valid !== (exp_q.size() != 0) ||
          ex_ready !== (exp_q.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand_status cyc %0d got cnt=%0d v=%b r=%b want cnt=%0d", c, count, wb_valid, ex_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        checks++;
        if ({wb_rd, wb_result} !== head) begin
          errors++; $display("FAIL rand_head cyc %0d got %h want %h", c, {wb_rd, wb_result}, head);
        end
      end
`ifdef ALU_WB_FWD_EN
      begin
        logic exp_hit;
        logic [DATA_W-1:0] exp_data;
        exp_hit = 1'b0; exp_data = '0;
        for (int k = exp_q.size() - 1; k >= 0 && !exp_hit; k--) begin
          if (fwd_rs != 0 && exp_q[k][EW-1 -: ADDR_W] == fwd_rs) begin
            exp_hit = 1'b1; exp_data = exp_q[k][DATA_W-1:0];
          end
        end
        checks++;
        if (fwd_hit !== exp_hit || fwd_data !== exp_data) begin
          errors++; $display("FAIL rand_fwd cyc %0d got %b/%h want %b/%h", c, fwd_hit, fwd_data, exp_hit, exp_data);
        end
      end
`endif
      tick();
    end
    drive_ex(0, 0, 0, 0);
    wb_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    wb_ready = 1'b0;
    checks++; if (count !== 0) begin errors++; $display("FAIL rand_drain got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_drop();
    test_back_to_back();
`ifdef ALU_WB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Writeback buffer directly downstream of `cv32e40p_alu`. It captures each ALU result with its destination register index into a small in-order FIFO and presents the entries to the register-file write port over a valid/ready handshake. This decouples ALU issue from write-port stalls. An optional lookup port forwards in-flight results to operand fetch.

## Interface
- `DEPTH`, 2: number of entries; power of two, at least 2.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: result width; matches ALU `result_o`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid_i` in 1: ALU result present this cycle.
- `ex_ready_o` out 1: buffer accepts a result this cycle.
- `ex_we_i` in 1: result must be written back; if 0, the beat is accepted and discarded.
- `ex_rd_i` in ADDR_W: destination register.
- `ex_result_i` in DATA_W: ALU `result_o`.
- `wb_valid_o` out 1: head entry valid.
- `wb_ready_i` in 1: write port consumes the head entry.
- `wb_rd_o` out ADDR_W: head destination register.
- `wb_result_o` out DATA_W: head data.
- `count_o` out $clog2(DEPTH)+1: occupied entries.
- `fwd_rs_i` in ADDR_W: register being read (only with the macro).
- `fwd_hit_o` out 1: an in-flight entry targets `fwd_rs_i` (only with the macro).
- `fwd_data_o` out DATA_W: forwarded data (only with the macro).

## Operation
- Accept: `ex_valid_i && ex_ready_o`.
- Push: accept && `ex_we_i` && `ex_rd_i != 0`. Writes to x0 and beats with `ex_we_i`=0 are accepted and dropped, with no state change.
- Pop: `wb_valid_o && wb_ready_i`. The head pointer advances.
- `ex_ready_o` = `count_o != DEPTH`. It is derived from registered count only; there is no combinational path from `wb_ready_i`.
- When full, no accept occurs even if a pop happens the same cycle. `ex_ready_o` rises the cycle after the pop.
- When a push and a pop occur in the same cycle with 0 < count < DEPTH, count is unchanged and both pointers advance.
- When empty, `wb_valid_o`=0 and a push the same cycle does not bypass to the outputs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately so full and empty are never ambiguous.
- Order is strict FIFO; no entry is reordered or merged.
- The `wb_*` data outputs are driven from the head storage slot. They are stable while `wb_valid_o`=1 and `wb_ready_i`=0.

## Timing
- Latency: a result pushed in cycle N appears on `wb_valid_o`/`wb_rd_o`/`wb_result_o` in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle.
- Reset values: `wb_valid_o`=0, `ex_ready_o`=1, `count_o`=0, `wb_rd_o`=0, `wb_result_o`=0, `fwd_hit_o`=0, `fwd_data_o`=0. Storage and pointers are cleared.
- Reset mid-operation discards all entries. `ex_valid_i` is ignored in a cycle where `rst`=1.
- Forwarding lookup is combinational from `fwd_rs_i` and registered storage, with no added cycle.

## Configuration
- Macro: `ALU_WB_FWD_EN`.
- Defined:
  - The `fwd_*` ports exist.
  - `fwd_hit_o`=1 when any valid entry has `rd == fwd_rs_i` and `fwd_rs_i != 0`.
  - `fwd_data_o` is the data of the youngest matching entry; it is 0 when there is no hit.
  - Entries pushed in the current cycle are not visible to the lookup.
- Undefined: the `fwd_*` ports and comparators are absent. FIFO behaviour is identical.

## Test plan
- Reset, then idle: `count_o`=0, `wb_valid_o`=0, `ex_ready_o`=1. Assert `rst` with 2 entries held: next cycle `count_o`=0 and `wb_valid_o`=0.
- Single push rd=5, result=0xDEADBEEF, `wb_ready_i`=0: next cycle `wb_valid_o`=1, rd=5, data=0xDEADBEEF. These stay stable until `wb_ready_i`=1, then `count_o` drops to 0.
- Fill DEPTH=2 with rd=1/0x11 then rd=2/0x22 while `wb_ready_i`=0: `ex_ready_o`=0 and a third beat is not accepted. Pop: the head is 0x11, and `ex_ready_o`=1 the following cycle.
- Push rd=0 with 0xFFFFFFFF, then push `ex_we_i`=0 with rd=7: both are accepted, `count_o` stays 0, and `wb_valid_o` stays 0.
- Streaming with continuous valid and ready, 8 results 0..7 on rd=1..8: output order is 0..7 and `count_o` stays ≤1 throughout.
- `ALU_WB_FWD_EN` defined, entries rd=3/0xA, rd=3/0xB, rd=4/0xC:
  - `fwd_rs_i`=3 gives hit with 0xB.
  - `fwd_rs_i`=4 gives hit with 0xC.
  - `fwd_rs_i`=0 gives no hit and 0.
